// File: rtl/bnn_dotprod_pkg.sv
// Shared types and helpers for the BNN dot-product blocks: FSM states,
// popcount width, and the sign-threshold compare.
package bnn_dotprod_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int pop_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Callers zero-extend 2*pop and the (already width-truncated) threshold.
  function automatic logic thresh_ge(input logic [31:0] two_pop, input logic [31:0] thresh);
    return two_pop >= thresh;
  endfunction

endpackage

// File: rtl/bnn_dotproduct_seq_if.sv
// Beat-in / result-out bus of bnn_dotproduct_seq. pcount exists only when
// BNN_DOTPROD_RAW_OUT_EN is defined.
interface bnn_dotproduct_seq_if
  import bnn_dotprod_pkg::*;
#(
  parameter int CHUNK   = 16,
  parameter int NCHUNKS = 4,
  parameter int NCH     = 4
);
  localparam int CW = pop_width(CHUNK * NCHUNKS);

  // Both sides use valid/ready: a transfer happens on a rising clk edge where
  // valid && ready; valid must not wait on ready, ready never depends on valid.
  logic                 in_valid;
  logic                 in_ready;
  logic [CHUNK-1:0]     g_chunk;
  logic [NCH*CHUNK-1:0] e_chunk;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH-1:0]       o;
`ifdef BNN_DOTPROD_RAW_OUT_EN
  logic [NCH*CW-1:0]    pcount;
`endif

  modport slave (
    input  in_valid, g_chunk, e_chunk, out_ready,
`ifdef BNN_DOTPROD_RAW_OUT_EN
    output pcount,
`endif
    output in_ready, out_valid, o
  );

  modport master (
    output in_valid, g_chunk, e_chunk, out_ready,
`ifdef BNN_DOTPROD_RAW_OUT_EN
    input  pcount,
`endif
    input  in_ready, out_valid, o
  );

endinterface

// File: rtl/bnn_dotproduct_seq_xnor_popcount_chunk.sv
// Combinational XNOR + popcount of one CHUNK-bit activation/weight slice.
module xnor_popcount_chunk #(
  parameter int CHUNK = 16,
  parameter int CW    = 7
) (
  input  logic [CHUNK-1:0] i_g,
  input  logic [CHUNK-1:0] i_e,
  output logic [CW-1:0]    o_pop
);

  logic [CHUNK-1:0] w_match;

  assign w_match = ~(i_g ^ i_e);

  always_comb begin
    o_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_pop = o_pop + CW'(w_match[i]);
    end
  end

endmodule

// File: rtl/bnn_dotproduct_seq.sv
// Multi-channel sequential XNOR-popcount dot product with sign output.
// Optional raw popcount output: define BNN_DOTPROD_RAW_OUT_EN.
module bnn_dotproduct_seq
  import bnn_dotprod_pkg::*;
#(
  parameter int CHUNK   = 16,
  parameter int NCHUNKS = 4,
  parameter int NCH     = 4,
  parameter int THRESH  = CHUNK * NCHUNKS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  bnn_dotproduct_seq_if.slave   bus,
  output state_t                o_dbg_state
);

  localparam int N  = CHUNK * NCHUNKS;
  localparam int CW = pop_width(N);
  localparam int BW = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
  localparam logic [CW:0] TH_W = THRESH[CW:0];

  state_t          r_state, w_next;
  logic [BW-1:0]   r_beat;
  logic [CW-1:0]   r_acc [NCH];
  logic [CW-1:0]   w_pop [NCH];
  logic [CW-1:0]   w_sum [NCH];
  logic [NCH-1:0]  w_sign;
  logic [NCH-1:0]  r_o;
  logic            w_accept, w_abort, w_take, w_last;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    xnor_popcount_chunk #(.CHUNK(CHUNK), .CW(CW)) u_pop (
      .i_g   (bus.g_chunk),
      .i_e   (bus.e_chunk[c*CHUNK +: CHUNK]),
      .o_pop (w_pop[c])
    );
    assign w_sum[c]  = r_acc[c] + w_pop[c];
    assign w_sign[c] = thresh_ge(32'({w_sum[c], 1'b0}), 32'(TH_W));
  end

  // HOLD still takes a beat when the result drains in the same cycle.
  assign bus.in_ready = (r_state == ACCUM) || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_abort      = (r_state == ACCUM) && clr;
  assign w_take       = w_accept && !w_abort;
  assign w_last       = (r_beat == BW'(NCHUNKS - 1));

  assign bus.out_valid = (r_state == HOLD);
  assign bus.o         = r_o;
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_state == ACCUM) begin
      if (w_take && w_last) w_next = HOLD;
    end else begin
      if (bus.out_ready) w_next = (w_take && w_last) ? HOLD : ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
      r_o    <= '0;
      for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
    end else if (w_abort) begin
      r_beat <= '0;
      for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
    end else if (w_take) begin
      if (w_last) begin
        r_beat <= '0;
        r_o    <= w_sign;
        for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
      end else begin
        r_beat <= r_beat + 1'b1;
        for (int c = 0; c < NCH; c++) r_acc[c] <= w_sum[c];
      end
    end
  end

`ifdef BNN_DOTPROD_RAW_OUT_EN
  logic [NCH*CW-1:0] r_pcount;
  logic [NCH*CW-1:0] w_sum_flat;

  for (genvar c = 0; c < NCH; c++) begin : g_flat
    assign w_sum_flat[c*CW +: CW] = w_sum[c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_pcount <= '0;
    else if (w_take && w_last)     r_pcount <= w_sum_flat;
  end

  assign bus.pcount = r_pcount;
`endif

endmodule
